// File: rtl/alu_seq_top.sv
// Sequential ALU: start-edge operand capture, 1-cycle ops, WIDTH-cycle shift-add
// multiplier, registered result/flags, and a scanned hex 7-segment readout.
module alu_seq_top #(
  parameter int WIDTH       = 8,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [2:0]        sel,
  input  logic              cin,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic              carry,
  output logic              zero,
  output logic              ovf,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic [1:0]        dbg_state
);
  localparam int SH_W  = $clog2(WIDTH);
  localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_MUL = 2'd2} state_t;
  state_t state_q, state_d;

  logic               start_q, start_edge, mul_last;
  logic [WIDTH-1:0]   a_q, b_q, mplier_q, result_q;
  logic [2:0]         sel_q;
  logic               cin_q, carry_q, zero_q, ovf_q, done_q;
  logic [2*WIDTH-1:0] acc_q, mcand_q, acc_nxt;
  logic [SH_W-1:0]    cnt_q;
  logic [REF_W-1:0]   ref_q;
  logic [DIG_W-1:0]   dig_q;

  assign start_edge = start && !start_q && (state_q == S_IDLE);
  assign mul_last   = (state_q == S_MUL) && (cnt_q == SH_W'(WIDTH - 1));
  assign acc_nxt    = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Single-cycle operations, evaluated on the captured operands
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry, alu_ovf;
  logic [WIDTH:0]     sum_w, diff_w;
  logic [2*WIDTH-1:0] shl_w, shr_w;
  always_comb begin
    sum_w     = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
    diff_w    = {1'b0, a_q} - {1'b0, b_q};
    shl_w     = {{WIDTH{1'b0}}, a_q} << b_q[SH_W-1:0];
    shr_w     = {a_q, {WIDTH{1'b0}}} >> b_q[SH_W-1:0];
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (sel_q)
      3'b000: begin
        alu_res   = sum_w[WIDTH-1:0];
        alu_carry = sum_w[WIDTH];
        alu_ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_w[WIDTH-1] != a_q[WIDTH-1]);
      end
      3'b001: begin
        alu_res   = diff_w[WIDTH-1:0];
        alu_carry = ~diff_w[WIDTH];
        alu_ovf   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_w[WIDTH-1] != a_q[WIDTH-1]);
      end
      3'b010: alu_res = a_q & b_q;
      3'b011: alu_res = a_q | b_q;
      3'b100: alu_res = a_q ^ b_q;
      // Bit just past the kept window is the last bit shifted out (0 for a zero shift)
      3'b110: begin
        alu_res   = shl_w[WIDTH-1:0];
        alu_carry = shl_w[WIDTH];
      end
      3'b111: begin
        alu_res   = shr_w[2*WIDTH-1:WIDTH];
        alu_carry = shr_w[WIDTH-1];
      end
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_edge) state_d = (sel == 3'b101) ? S_MUL : S_EXEC;
      S_EXEC:  state_d = S_IDLE;
      S_MUL:   if (mul_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    dbg_state = state_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= '0;
      cin_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      start_q <= start;
      done_q  <= 1'b0;
      if (start_edge) begin
        a_q      <= a;
        b_q      <= b;
        sel_q    <= sel;
        cin_q    <= cin;
        acc_q    <= '0;
        mcand_q  <= {{WIDTH{1'b0}}, a};
        mplier_q <= b;
        cnt_q    <= '0;
      end
      if (state_q == S_EXEC) begin
        result_q <= alu_res;
        carry_q  <= alu_carry;
        ovf_q    <= alu_ovf;
        zero_q   <= (alu_res == '0);
        done_q   <= 1'b1;
      end
      if (state_q == S_MUL) begin
        acc_q    <= acc_nxt;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + SH_W'(1);
        if (mul_last) begin
          result_q <= acc_nxt[WIDTH-1:0];
          carry_q  <= |acc_nxt[2*WIDTH-1:WIDTH];
          ovf_q    <= 1'b0;
          zero_q   <= (acc_nxt[WIDTH-1:0] == '0);
          done_q   <= 1'b1;
        end
      end
    end
  end

  assign done   = done_q;
  assign result = result_q;
  assign carry  = carry_q;
  assign zero   = zero_q;
  assign ovf    = ovf_q;

  // Display scan runs freely, independent of the operation FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_q <= '0;
      dig_q <= '0;
    end else if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
      ref_q <= '0;
      dig_q <= (dig_q == DIG_W'(DIGITS - 1)) ? '0 : dig_q + DIG_W'(1);
    end else begin
      ref_q <= ref_q + REF_W'(1);
    end
  end

  logic [4*DIGITS+WIDTH-1:0] disp_w;
  logic [3:0]                nib;
  always_comb begin
    disp_w = {{(4*DIGITS){1'b0}}, result_q};
    nib    = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_q == DIG_W'(i)) nib = disp_w[4*i +: 4];
    end
    an = ~(DIGITS'(1) << dig_q);
    case (nib)
      4'h0: seg = 7'b1000000;  4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;  4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;  4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;  4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;  4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;  4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;  4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;  default: seg = 7'b0001110;
    endcase
  end
endmodule
